// File: rtl/ysyx_22041412_hazard_ctrl_pkg.sv
// Shared stage indices and defaults for the pipeline hazard controller.
package ysyx_22041412_hazard_ctrl_pkg;

    typedef enum int {
        STG_PC  = 0,
        STG_IF  = 1,
        STG_ID  = 2,
        STG_EX  = 3,
        STG_MEM = 4,
        STG_WB  = 5
    } stage_e;

    localparam int DEF_NSTAGE = 6;
    localparam int DEF_SW     = $clog2(DEF_NSTAGE);
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_TMO    = 200;

    // A MEM stall freezes the whole pipe by default.
    localparam logic [DEF_NSTAGE-1:0] DEF_GLOBAL_MASK =
        DEF_NSTAGE'(1) << STG_MEM;

endpackage

// File: rtl/ysyx_22041412_hazard_ctrl_wdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles
// plus a timeout flag held until the first stall-free cycle.
module ysyx_22041412_stall_wdog #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    output logic [CNT_W-1:0] cnt,
    output logic             timeout
);

    logic [CNT_W-1:0] cnt_nxt;
    logic             hit;

    assign cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign hit     = (TIMEOUT != 0) && (32'(cnt_nxt) == TIMEOUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (active) begin
            cnt     <= cnt_nxt;
            timeout <= timeout | hit;
        end else begin
            cnt     <= '0;
            timeout <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_22041412_hazard_ctrl.sv
// Pipeline freeze/kill controller: per-stage stall and flush vectors,
// deferred flushes while the requester is frozen, stall watchdog.
module ysyx_22041412_hazard_ctrl
    import ysyx_22041412_hazard_ctrl_pkg::*;
#(
    parameter int                NSTAGE      = DEF_NSTAGE,
    parameter logic [NSTAGE-1:0] GLOBAL_MASK = NSTAGE'(DEF_GLOBAL_MASK),
    parameter int                SW          = $clog2(NSTAGE),
    parameter int                CNT_W       = DEF_CNT_W,
    parameter int                TIMEOUT     = DEF_TMO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              flush_req,
    input  logic [SW-1:0]     flush_stage,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              flush_pend,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              timeout
);

    logic              live_ok;
    logic              have;
    logic              blocked;
    logic              fire;
    logic [SW-1:0]     kf;
    logic [NSTAGE-1:0] hold;
    logic [NSTAGE-1:0] mask;
    logic              pend_vld;
    logic [SW-1:0]     pend_stage;

    assign live_ok = flush_req
                  && (flush_stage != '0)
                  && (32'(flush_stage) < NSTAGE);

    // Stage i holds when any stage at or above i requests a stall.
    always_comb begin
        hold = '0;
        hold[NSTAGE-1] = stall_req[NSTAGE-1];
        for (int i = NSTAGE-2; i >= 0; i--) begin
            hold[i] = stall_req[i] | hold[i+1];
        end
        if (|(stall_req & GLOBAL_MASK)) begin
            hold = '1;
        end
    end

    // Older requester wins when a live and a pending flush coexist.
    always_comb begin
        kf   = pend_stage;
        mask = '0;
        if (live_ok && (!pend_vld || (flush_stage > pend_stage))) begin
            kf = flush_stage;
        end
        have = live_ok || pend_vld;
        for (int i = 0; i < NSTAGE; i++) begin
            mask[i] = (32'(kf) > i);
        end
        blocked = |(stall_req & ~mask);
        fire    = have && !blocked;
    end

    assign stall = !rst ? '0 : (fire ? (hold & ~mask) : hold);
    assign flush = (rst && fire) ? mask : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld   <= 1'b0;
            pend_stage <= '0;
        end else begin
            pend_vld <= have && blocked;
            if (have && blocked) begin
                pend_stage <= kf;
            end
        end
    end

    assign flush_pend = pend_vld;

    ysyx_22041412_stall_wdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .active  (|stall),
        .cnt     (stall_cnt),
        .timeout (timeout)
    );

    a_flush_stage: assert property (
        @(posedge clk) disable iff (!rst)
        flush_req |-> (flush_stage != '0 && 32'(flush_stage) < NSTAGE)
    );

endmodule
